lsu_dmem: RTL and testbench
===========================

# lsu_dmem

Load/store unit between the execute stage and the data port of the unified `memory` block. Accepts one load or store request at a time, drives the word-addressed data port (`addr_d`, `wen`, `wdata`, `rdata`), and performs byte/halfword lane extraction with sign/zero extension on loads. Because the memory writes only whole words, sub-word stores use an internal read-modify-write sequence. Returns a single-cycle response to the pipeline.

## Interface
Parameters:
- `MEM_LATENCY`, 1, cycles from `mem_addr` valid to `mem_rdata` valid; legal range 1..7.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle, can accept.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  zero-extend loads when 1.
- `req_addr`  in  `WORD_LEN`  byte address.
- `req_wdata`  in  `WORD_LEN`  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  `WORD_LEN`  extended load data; 0 for stores and errors.
- `resp_err`  out  1  request rejected, no memory access performed.
- `mem_addr`  out  `WORD_LEN`  to `addr_d`; always word-aligned.
- `mem_rdata`  in  `WORD_LEN`  from `rdata`.
- `mem_wen`  out  1  to `wen`.
- `mem_wdata`  out  `WORD_LEN`  to `wdata`.

## Operation
- States: IDLE, READ, WRITE, RESP. Reset → IDLE.
- `req_ready` = (state == IDLE). Handshake when `req_valid && req_ready`; addr, size, unsigned, wen, and wdata are latched.
- `req_valid` outside IDLE is ignored; there is no queueing.
- IDLE → RESP directly with `resp_err=1` on illegal size or misalignment (see Configuration).
- Load: IDLE → READ → RESP.
- Word store: IDLE → WRITE → RESP.
- Byte/half store: IDLE → READ → WRITE → RESP.
- READ: `mem_addr = {addr[31:2],2'b00}`. A 3-bit counter runs 0..MEM_LATENCY. `mem_rdata` is captured at the end of the cycle where count == MEM_LATENCY, so READ lasts MEM_LATENCY+1 cycles.
- Load extraction:
  - Byte lane = `addr[1:0]`; half lane = `addr[1]`.
  - Sign-extend from bit 7/15 unless `req_unsigned`; word passes through.
  - Result registered into `resp_rdata`.
- Store merge:
  - Byte replaces lane `addr[1:0]` of the captured word with `req_wdata[7:0]`.
  - Half replaces lane `addr[1]` with `req_wdata[15:0]`.
  - Word uses `req_wdata` unchanged.
- WRITE: exactly one cycle with `mem_wen=1`, `mem_addr` aligned, `mem_wdata` = merged word.
- RESP: `resp_valid=1` for one cycle, then IDLE.
- `mem_wen` is decoded from state only; it is never high outside WRITE.

## Timing
- Reset values: `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_addr=0`, `mem_wen=0`, `mem_wdata=0`.
- Accept in cycle T, L = MEM_LATENCY:
  - Load: READ T+1..T+1+L, `resp_valid` at T+2+L.
  - Word store: `mem_wen` at T+1, `resp_valid` at T+2.
  - Sub-word store: READ T+1..T+1+L, `mem_wen` at T+2+L, `resp_valid` at T+3+L.
  - Error: `resp_valid`+`resp_err` at T+1.
- Next accept is possible in the cycle after RESP.
- Async reset mid-operation: state → IDLE immediately, `mem_wen` drops combinationally, latched request discarded, no response issued.
- `resp_rdata`/`resp_err` hold their values until the next RESP.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a half with `addr[0]=1`, or a word with `addr[1:0]!=0`, takes the error path with no memory access.
- Undefined: misaligned low address bits are forced to zero per size (half clears bit 0, word clears bits 1:0) and the access proceeds normally.
- Size 11 takes the error path in both builds.

## Test plan
All cases use L=1, with word 0x10 preloaded to 0x807060F0.
- lb 0x13 → `resp_valid` at T+3, `resp_rdata=0xFFFFFF80`; lbu 0x13 → 0x00000080; lh 0x12 → 0xFFFF8070.
- sb 0xAB to 0x11 → `mem_wen` high only at T+3 with `mem_wdata=0x8070ABF0`; lw 0x10 then returns 0x8070ABF0.
- sw 0xDEADBEEF to 0x20 → `mem_wen` at T+1, `resp_valid` at T+2; lw 0x20 returns 0xDEADBEEF.
- lh 0x11:
  - With the macro: `resp_err=1`, `resp_rdata=0` at T+1, `mem_wen` never high.
  - Without the macro: reads 0x10, `resp_rdata=0x000060F0`.
- `req_valid` held high through a load → `req_ready` low T+1..T+3; second request accepted at T+4.
- `rst_n` low during WRITE of sh → `mem_wen` falls before the edge, memory unchanged, no `resp_valid`, `req_ready=1` after release.

Source files
------------

// File: rtl/lsu_dmem.sv
// Load/store unit in front of a word-wide data memory: byte/half extraction on loads,
// read-modify-write for sub-word stores. Define LSU_MISALIGN_TRAP_EN to trap misaligned halves/words.
module lsu_dmem #(
  parameter int MEM_LATENCY = 1,
  parameter int WORD_LEN    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic [WORD_LEN-1:0] mem_addr,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  logic [1:0]          state_reg;
  logic [2:0]          cnt_reg;
  logic [1:0]          lo_reg;
  logic [1:0]          size_reg;
  logic                uns_reg;
  logic                wen_reg;
  logic [15:0]         wdata_reg;
  logic [WORD_LEN-1:0] mem_addr_reg;
  logic [WORD_LEN-1:0] mem_wdata_reg;
  logic [WORD_LEN-1:0] resp_rdata_reg;
  logic                resp_err_reg;

  logic                bad_req;
  logic [WORD_LEN-1:0] eff_addr;

  always_comb begin
    bad_req  = (req_size == 2'b11);
    eff_addr = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00))
      bad_req = 1'b1;
`else
    // Misaligned accesses silently round down to the natural boundary of the size.
    if (req_size == 2'b01)
      eff_addr[0] = 1'b0;
    else if (req_size == 2'b10)
      eff_addr[1:0] = 2'b00;
`endif
  end

  function automatic logic [WORD_LEN-1:0] load_extract(
    input logic [WORD_LEN-1:0] word,
    input logic [1:0]          lo,
    input logic [1:0]          size,
    input logic                uns
  );
    logic [7:0]          b;
    logic [15:0]         h;
    logic [WORD_LEN-1:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = uns ? {{(WORD_LEN-8){1'b0}}, b}  : {{(WORD_LEN-8){b[7]}}, b};
      2'b01:   r = uns ? {{(WORD_LEN-16){1'b0}}, h} : {{(WORD_LEN-16){h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [WORD_LEN-1:0] store_merge(
    input logic [WORD_LEN-1:0] word,
    input logic [1:0]          lo,
    input logic [1:0]          size,
    input logic [15:0]         wd
  );
    logic [WORD_LEN-1:0] r;
    r = word;
    case (size)
      2'b00:   r[{lo, 3'b000} +: 8]     = wd[7:0];
      2'b01:   r[{lo[1], 4'b0000} +: 16] = wd;
      default: r = word;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= 3'd0;
      lo_reg         <= 2'b00;
      size_reg       <= 2'b00;
      uns_reg        <= 1'b0;
      wen_reg        <= 1'b0;
      wdata_reg      <= 16'd0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (bad_req) begin
              resp_rdata_reg <= '0;
              resp_err_reg   <= 1'b1;
              state_reg      <= RESP;
            end else begin
              lo_reg       <= eff_addr[1:0];
              size_reg     <= req_size;
              uns_reg      <= req_unsigned;
              wen_reg      <= req_wen;
              wdata_reg    <= req_wdata[15:0];
              mem_addr_reg <= {eff_addr[WORD_LEN-1:2], 2'b00};
              cnt_reg      <= 3'd0;
              if (req_wen && req_size == 2'b10) begin
                mem_wdata_reg <= req_wdata;
                state_reg     <= WRITE;
              end else begin
                state_reg <= READ;
              end
            end
          end
        end
        READ: begin
          if (cnt_reg == LAT) begin
            if (wen_reg) begin
              mem_wdata_reg <= store_merge(mem_rdata, lo_reg, size_reg, wdata_reg);
              state_reg     <= WRITE;
            end else begin
              resp_rdata_reg <= load_extract(mem_rdata, lo_reg, size_reg, uns_reg);
              resp_err_reg   <= 1'b0;
              state_reg      <= RESP;
            end
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        WRITE: begin
          resp_rdata_reg <= '0;
          resp_err_reg   <= 1'b0;
          state_reg      <= RESP;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // mem_wen is a pure state decode so an async reset kills a pending write at once.
  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign mem_wen    = (state_reg == WRITE);
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_lsu_dmem.sv
// Scoreboard bench for lsu_dmem with a latency-L word memory model; honours LSU_MISALIGN_TRAP_EN.
module tb_lsu_dmem;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [31:0] mem_wdata;

  lsu_dmem #(.MEM_LATENCY(L), .WORD_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Memory model: word array, read data delayed L cycles after the address.
  logic        preload = 1'b1;
  logic [31:0] mem [0:63];
  logic [31:0] rd_pipe [L];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem[4] <= 32'h807060F0;
    end else if (mem_wen) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  always @(posedge clk) begin
    rd_pipe[0] <= mem[mem_addr[7:2]];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  always @(negedge clk) begin
    if (resp_valid) begin
      if (rq.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = rq.pop_front();
        $display("resp cyc=%0d rdata=%08h err=%0b", cyc, resp_rdata, resp_err);
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (mem_wen) begin
      if (wq.size() == 0) begin
        check("wen_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        $display("write cyc=%0d addr=%08h data=%08h", cyc, mem_addr, mem_wdata);
        check("wr_addr", mem_addr, w.addr);
        check("wr_data", mem_wdata, w.data);
        check("wr_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
  end

  // resp_lat / wr_lat < 0 means no response / no write is expected.
  task automatic send(input logic wen, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int resp_lat, input int wr_lat, output int t);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'd1, 32'd0);
    t = cyc;
    if (resp_lat >= 0) rq.push_back('{exp_rdata, exp_err, t + resp_lat});
    if (wr_lat >= 0) wq.push_back('{{addr[31:2], 2'b00}, exp_rdata, t + wr_lat});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) begin
      check("drain_timeout", 32'd1, 32'd0);
      rq.delete();
      wq.delete();
    end
  endtask

  // Store expectations reuse exp_rdata as the expected merged write word; responses carry 0.
  task automatic load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                      input logic [31:0] exp);
    int t;
    send(1'b0, size, uns, addr, 32'd0, exp, 1'b0, L + 2, -1, t);
    drain();
  endtask

  task automatic store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] merged);
    int t;
    if (size == 2'b10) send(1'b1, size, 1'b0, addr, wdata, merged, 1'b0, 2, 1, t);
    else               send(1'b1, size, 1'b0, addr, wdata, merged, 1'b0, L + 3, L + 2, t);
    // write entry holds the merged word; the response itself must return 0
    rq[rq.size()-1].rdata = 32'd0;
    drain();
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    preload = 1'b0;
    rst_n = 1'b1;

    load(2'b00, 1'b0, 32'h13, 32'hFFFFFF80);
    load(2'b00, 1'b1, 32'h13, 32'h00000080);
    load(2'b01, 1'b0, 32'h12, 32'hFFFF8070);
    load(2'b01, 1'b1, 32'h12, 32'h00008070);
    load(2'b00, 1'b0, 32'h10, 32'hFFFFFFF0);
    repeat (3) @(posedge clk);
    #1;
    check("resp_rdata_hold", resp_rdata, 32'hFFFFFFF0);

`ifdef LSU_MISALIGN_TRAP_EN
    send(1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 32'd0, 1'b1, 1, -1, t);
    drain();
`else
    load(2'b01, 1'b0, 32'h11, 32'h000060F0);
`endif

    send(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1, 1, -1, t);
    drain();
    send(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 32'd0, 1'b1, 1, -1, t);
    drain();

    store(2'b00, 32'h11, 32'h000000AB, 32'h8070ABF0);
    load(2'b10, 1'b0, 32'h10, 32'h8070ABF0);
    store(2'b10, 32'h20, 32'hDEADBEEF, 32'hDEADBEEF);
    load(2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
    store(2'b01, 32'h22, 32'hFFFF1234, 32'h1234BEEF);
    load(2'b10, 1'b0, 32'h20, 32'h1234BEEF);

    // req_valid held high: second request must wait until the first has responded
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h20;
    check("busy_ready_t0", {31'd0, req_ready}, 32'd1);
    t = cyc;
    rq.push_back('{32'h1234BEEF, 1'b0, t + L + 2});
    @(posedge clk); #1;
    req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h10;
    for (int k = 1; k <= L + 2; k++) begin
      check("busy_ready_low", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    check("busy_ready_again", {31'd0, req_ready}, 32'd1);
    rq.push_back('{32'h000000F0, 1'b0, cyc + L + 2});
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    // reset asserted during the WRITE of a half store: write must be suppressed
    send(1'b1, 2'b01, 1'b0, 32'h12, 32'h00005555, 32'd0, 1'b0, -1, -1, t);
    repeat (L + 1) @(posedge clk);
    #1;
    check("rst_wen_before", {31'd0, mem_wen}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_wen_dropped", {31'd0, mem_wen}, 32'd0);
    check("rst_ready_mid", {31'd0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_rdata_cleared", resp_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_after", {31'd0, req_ready}, 32'd1);
    load(2'b10, 1'b0, 32'h10, 32'h8070ABF0);

    repeat (2) @(posedge clk);
    check("queues_empty", 32'(rq.size() + wq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
